// File: rtl/sample_buffer_ctrl.sv
// sample_buffer_ctrl: circular FIFO over a 16x8 sample memory with a one-word output register.
module sample_buffer_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              flush,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rst_n
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic {IDLE, RD_WAIT} state_t;
  state_t state;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic rd_issue, wr_do;
  always_comb begin
    full      = count == DEPTH;
    rd_issue  = !rst && !flush && state == IDLE && !m_valid && count != '0;
    s_ready   = !rst && !flush && !full && !rd_issue;
    wr_do     = s_valid && s_ready;
    mem_read  = rd_issue;
    mem_write = wr_do;
    mem_addr  = wr_do ? wr_ptr : rd_ptr;
    mem_wdata = s_data;
    mem_rst_n = !rst;
    empty     = count == '0 && !m_valid && state != RD_WAIT;
  end
  // flush mirrors reset on every register; only mem_rst_n tells them apart
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
    end else begin
      wr_ptr   <= wr_ptr + ADDR_W'(wr_do);
      rd_ptr   <= rd_ptr + ADDR_W'(rd_issue);
      count    <= count + (ADDR_W+1)'(wr_do) - (ADDR_W+1)'(rd_issue);
      overflow <= overflow | (s_valid & full);
      state    <= rd_issue ? RD_WAIT : IDLE;
      if (state == RD_WAIT) begin
        m_data  <= mem_rdata;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/sample_buffer_ctrl.md
Name: sample_buffer_ctrl

Overview:
- Initiator for the node's 16x8 sample memory; drives its addr/data_in/write/read/rst_n pins and consumes its registered data_out.
- Presents memory as a circular FIFO: sensor side pushes samples (valid/ready), radio side pops them (valid/ready) through a one-word output register.
- Sits between the ADC sampling front end and the packet framer.

Parameters:
- ADDR_W, 4, memory address width; DEPTH = 2**ADDR_W = 16 words
- DATA_W, 8, sample width

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- s_data  input  DATA_W  sample from sensor
- s_valid  input  1  sample present
- s_ready  output  1  sample accepted this cycle when s_valid&&s_ready
- m_data  output  DATA_W  sample to radio
- m_valid  output  1  m_data valid
- m_ready  input  1  radio takes m_data when m_valid&&m_ready
- flush  input  1  synchronous buffer clear
- count  output  ADDR_W+1  words held in memory (excludes output register)
- full  output  1  count==DEPTH
- empty  output  1  count==0 && !m_valid && state!=RD_WAIT
- overflow  output  1  sticky: push attempted while full
- mem_addr  output  ADDR_W  to memory addr
- mem_wdata  output  DATA_W  to memory data_in
- mem_write  output  1  to memory write
- mem_read  output  1  to memory read
- mem_rdata  input  DATA_W  from memory data_out (registered, valid cycle after read)
- mem_rst_n  output  1  = ~rst, combinational; clears memory during reset

Behaviour:
- Reset (rst=1 at edge): wr_ptr=rd_ptr=0, count=0, m_valid=0, m_data=0, overflow=0, state=IDLE. Combinational outputs during reset: s_ready=0, mem_write=0, mem_read=0, mem_rst_n=0.
- States: IDLE, RD_WAIT.
- mem_write and mem_read never high in the same cycle; mem_addr=wr_ptr when writing, rd_ptr otherwise.
- Read issue (IDLE, !flush, !m_valid, count>0): mem_read=1, mem_addr=rd_ptr; s_ready=0 that cycle; at edge rd_ptr++ (mod DEPTH), count--, state->RD_WAIT. Read issue beats write when the output register is empty.
- RD_WAIT: mem_rdata valid; at edge m_data<=mem_rdata, m_valid<=1, state->IDLE. Writes allowed in RD_WAIT (memory data_out is unaffected by writes).
- Read latency: issue cycle N, m_valid=1 from cycle N+2.
- Write: s_ready = !rst && !flush && !full && !(read issue this cycle). When s_valid&&s_ready: mem_write=1, mem_addr=wr_ptr, mem_wdata=s_data; at edge wr_ptr++ (mod DEPTH), count++. Sustained one write per cycle while m_valid=1.
- Pop: m_valid&&m_ready clears m_valid at edge. m_data holds until popped. The next read issue is no earlier than the cycle after the pop, so the cadence is 3 cycles/word when draining.
- count: write and read issue never coincide, so count changes by at most ±1 per cycle. Wrap of pointers is silent; full/empty come from count only.
- full: s_ready=0; a source holding s_valid=1 sets overflow=1 at edge. Overflow stays set until rst or flush; the sample is not written.
- flush (priority over all but rst): same register effects as reset, except mem_rst_n stays 1 (memory contents kept, not cleared). An in-flight RD_WAIT is abandoned and its data discarded.
- Reset mid-RD_WAIT: as reset; m_valid=0.

Test Plan:
- Reset, push 0x11,0x22,0x33 back-to-back with m_ready=0 -> mem_write pulses at addrs 0,1,2. The first read issues after the last push or in a gap; m_data=0x11 with m_valid=1 two cycles after the read issue. count settles at 2 with m_valid=1.
- Continuous push 17 samples with m_ready=0 -> 16 words stored (count=16, full=1) plus 1 in the output register. Push 18 held -> s_ready=0, overflow=1 and sticky.
- Fill 16, drain all with m_ready=1 -> data in order. rd_ptr wraps 15->0. Final empty=1, count=0, mem_read/mem_write never both high.
- Push 20 with interleaved pops (m_ready toggling) -> output order equals input order; pointers wrap through address 0 correctly.
- Flush asserted during RD_WAIT with count=5 -> next cycle count=0, m_valid=0, overflow=0, empty=1. mem_rst_n stays 1. Subsequent push 0xA5 is popped as 0xA5.
- rst pulse mid-stream -> mem_rst_n=0 that cycle, all state cleared. The first post-reset push writes addr 0.
